// File: rtl/int_ctrl_pkg.sv
// int_pkg: shared sizes, level type, FSM encoding and stack entry
// for the nestable interrupt controller.
package int_pkg;

  localparam int NUM_SRC = 3;
  localparam int DEPTH   = 3;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] VEC_BASE   = 32'h0000_0100;
  localparam logic [PC_W-1:0] VEC_STRIDE = 32'h0000_0010;

  localparam int LVL_W = $clog2(NUM_SRC + 1);
  localparam int DEP_W = $clog2(DEPTH + 1);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef logic [LVL_W-1:0] lvl_t;
  typedef logic [SRC_W-1:0] src_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_TAKE  = 2'd1;
  localparam state_t ST_GUARD = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    lvl_t            lvl;
  } stk_t;

  function automatic src_t hi_idx(
    input logic [NUM_SRC-1:0] v
  );
    src_t r;
    r = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (v[i]) r = SRC_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/int_ctrl_lifo.sv
// int_lifo: shift-register return stack of {pc, lvl} entries;
// the top of stack always lives in slot 0.
module int_lifo
  import int_pkg::*;
#(
  parameter int D = DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  stk_t                   din,
  output stk_t                   top,
  output logic [$clog2(D+1)-1:0] depth,
  output logic                   full,
  output logic                   empty
);

  localparam int CW = $clog2(D + 1);

  stk_t          mem [D];
  logic [CW-1:0] cnt_q;

  assign full  = (cnt_q == CW'(D));
  assign empty = (cnt_q == '0);
  assign depth = cnt_q;
  assign top   = mem[0];

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (push && !full)
      cnt_q <= cnt_q + CW'(1);
    else if (pop && !empty)
      cnt_q <= cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[0] <= din;
      for (int i = 1; i < D; i++)
        mem[i] <= mem[i-1];
    end else if (pop) begin
      for (int i = 0; i < D - 1; i++)
        mem[i] <= mem[i+1];
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: nestable interrupt controller beside EX.
// Build with INT_NEST_EN for preemption; default is single-level.
module int_ctrl
  import int_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] clr_i,
  input  logic               int_en_i,
  input  logic               stall_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               eret_i,
  output logic               interrupt_o,
  output logic [PC_W-1:0]    vector_o,
  output logic               eret_ack_o,
  output logic [PC_W-1:0]    epc_o,
  output logic [LVL_W-1:0]   level_o,
  output logic [DEP_W-1:0]   depth_o,
  output logic [NUM_SRC-1:0] pending_o
);

`ifdef INT_NEST_EN
  localparam int EFF_D = DEPTH;
`else
  localparam int EFF_D = 1;
`endif
  localparam int EW = $clog2(EFF_D + 1);

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pend_q;
  state_t             state_q;
  state_t             state_d;
  src_t               src_q;
  logic [PC_W-1:0]    vec_q;
  lvl_t               level_q;
  logic [PC_W-1:0]    epc_q;
  logic               ack_q;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] tk_clr;
  src_t               hp;
  lvl_t               cand;
  logic [PC_W-1:0]    vec;
  logic               nest_ok;
  logic               take;
  logic               push;
  logic               pop;

  stk_t               top;
  logic [EW-1:0]      lifo_cnt;
  logic               full;
  logic               empty;

  assign rise = irq_i & ~irq_q;
  assign hp   = hi_idx(pend_q);
  assign cand = (|pend_q) ? lvl_t'(hp) + lvl_t'(1) : '0;
  assign vec  = VEC_BASE + PC_W'(hp) * VEC_STRIDE;

`ifdef INT_NEST_EN
  assign nest_ok = 1'b1;
`else
  assign nest_ok = (level_q == '0);
`endif

  // eret has priority over a new take in the same cycle
  assign take = (state_q == ST_RUN) & int_en_i & ~stall_i
              & ~eret_i & (cand > level_q) & ~full & nest_ok;
  assign pop  = (state_q == ST_RUN) & eret_i & ~empty;
  assign push = (state_q == ST_TAKE);

  assign tk_clr = push ? (NUM_SRC'(1) << src_q) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (pop)       state_d = ST_GUARD;
        else if (take) state_d = ST_TAKE;
      end
      ST_TAKE:  state_d = ST_GUARD;
      ST_GUARD: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q   <= '0;
      pend_q  <= '0;
      state_q <= ST_RUN;
      src_q   <= '0;
      vec_q   <= '0;
      level_q <= '0;
      epc_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      irq_q   <= irq_i;
      pend_q  <= (pend_q & ~(clr_i | tk_clr)) | rise;
      state_q <= state_d;
      ack_q   <= pop;
      if (take) begin
        src_q <= hp;
        vec_q <= vec;
      end
      if (push) begin
        level_q <= lvl_t'(src_q) + lvl_t'(1);
      end else if (pop) begin
        level_q <= top.lvl;
        epc_q   <= top.pc;
      end
    end
  end

  int_lifo #(
    .D (EFF_D)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ('{pc: pc_i, lvl: level_q}),
    .top   (top),
    .depth (lifo_cnt),
    .full  (full),
    .empty (empty)
  );

  assign interrupt_o = push;
  assign vector_o    = vec_q;
  assign eret_ack_o  = ack_q;
  assign epc_o       = epc_q;
  assign level_o     = level_q;
  assign depth_o     = DEP_W'(lifo_cnt);
  assign pending_o   = pend_q;

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Multi-source, nestable interrupt controller for the pipelined CPU.
- Produces the one-cycle `interrupt` flush pulse and the handler vector that the pipeline registers and NPC consume.
- Keeps a LIFO of return PCs and priority levels, and restores both when an `eret` reaches EX.
- Sits beside the EX stage. It is the source end of the `interrupt`/`eret` flush protocol that the ID/EX register obeys.

Parameters:
- NUM_SRC, 3, number of interrupt sources; source index i has priority i+1, higher index wins.
- DEPTH, 3, maximum nesting depth (LIFO entries).
- PC_W, 32, PC width; addresses are word addresses (sequential PC is PC+1).
- VEC_BASE, 32'h0000_0100, vector of source 0.
- VEC_STRIDE, 32'h10, vector spacing per source.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- irq_i  in  NUM_SRC  raw level requests; each rising edge latches pending.
- clr_i  in  NUM_SRC  software clear of pending bits.
- int_en_i  in  1  global enable.
- stall_i  in  1  pipeline halted or bubbling; no interrupt may be taken.
- pc_i  in  PC_W  resume PC, i.e. the PC of the instruction in EX being squashed.
- eret_i  in  1  `eret` present in EX this cycle.
- interrupt_o  out  1  one-cycle flush/redirect pulse.
- vector_o  out  PC_W  handler address; valid while interrupt_o=1.
- eret_ack_o  out  1  one-cycle pulse: pop performed, epc_o valid.
- epc_o  out  PC_W  restored PC; held until the next pop.
- level_o  out  log2(NUM_SRC+1)  current service level, 0 = main program.
- depth_o  out  log2(DEPTH+1)  LIFO occupancy.
- pending_o  out  NUM_SRC  pending bits.

Behaviour:
- Reset: all outputs 0; pending=0, irq_q=0, LIFO empty, FSM=RUN. Reset mid-service discards the whole LIFO.
- Edge detect: irq_q<=irq_i each cycle. pending[i] is set by irq_i[i]&~irq_q[i] and cleared by clr_i[i] or by being taken. Set beats clear in the same cycle.
- Candidate: hp = highest set pending index; cand_lvl = hp+1 (0 if none).
- take = (FSM==RUN) & int_en_i & ~stall_i & ~eret_i & (cand_lvl>level_o) & (depth_o<DEPTH).
- FSM states: RUN, TAKE, GUARD.
  - RUN & eret_i & depth_o>0 -> pop; next state GUARD.
  - RUN & take -> next state TAKE.
  - TAKE -> GUARD unconditionally.
  - GUARD -> RUN after 1 cycle, which lets the flushed pipeline present a valid pc_i.
- Take (registered, visible the cycle after the decision), in the TAKE cycle:
  - interrupt_o=1 and vector_o=VEC_BASE+hp*VEC_STRIDE.
  - {pc_i, level_o} is pushed to the LIFO.
  - level_o<=hp+1.
  - pending[hp] cleared.
- Pop, on the cycle after eret_i is accepted:
  - eret_ack_o=1.
  - epc_o<=top.pc; level_o<=top.lvl; depth decremented.
  - Lower-priority pending requests then become eligible after GUARD.
- eret_i with depth 0: ignored. No ack; epc_o and level_o unchanged.
- eret_i and take in the same cycle: eret wins; the pending bit is kept.
- eret_i while in TAKE or GUARD: accepted and processed once RUN is re-entered, only if eret_i is still asserted then. The pipeline holds EX during the flush, so no eret is lost.
- depth_o==DEPTH: further requests stay pending until a pop.
- interrupt_o and eret_ack_o are never high together.
- Width rules:
  - vector arithmetic is unsigned PC_W, wrapping modulo 2^PC_W.
  - level uses 0..NUM_SRC.

Optional Feature:
- INT_NEST_EN defined: preemption as above, with a LIFO of DEPTH entries.
- INT_NEST_EN undefined:
  - take additionally requires level_o==0.
  - Effective depth is 1; the LIFO reduces to a single EPC/level register.
  - depth_o is 0 or 1.

Decomposition:
- Package int_pkg holds:
  - NUM_SRC, DEPTH, PC_W, VEC_BASE and VEC_STRIDE defaults;
  - the level type;
  - FSM state encoding (RUN/TAKE/GUARD);
  - the stack-entry struct {pc, lvl}.
- One sub-module, int_lifo: a DEPTH-entry push/pop stack exposing top, depth, full and empty.
  - Push and pop are never issued in the same cycle.

Test Plan:
- Single IRQ:
  - Stimulus: irq_i[0] rises, pc_i=32'h20, int_en_i=1.
  - Response: 2 cycles later interrupt_o=1 with vector_o=32'h100; then level_o=1, depth_o=1.
  - Then eret_i -> eret_ack_o=1, epc_o=32'h20, level_o=0.
- Nesting:
  - Stimulus: take irq0 at pc 32'h20; in the handler, irq2 at pc_i=32'h105.
  - Response: vector 32'h120, level 3, depth 2.
  - Then two erets -> epc 32'h105 then 32'h20.
- Priority/no-preempt:
  - Stimulus: in the irq2 handler, raise irq1.
  - Response: stays pending, with no interrupt_o until after eret; then vector 32'h110.
- Blocking:
  - Stimulus: stall_i=1 or int_en_i=0 with irq0 pending.
  - Response: no interrupt_o. On release, it fires the next cycle.
- Simultaneous:
  - Stimulus: eret_i and a new higher-priority edge in the same cycle.
  - Response: pop first (eret_ack_o); the interrupt follows after GUARD, never in the same cycle.
- Full/reset:
  - Stimulus: DEPTH=3 reached, then irq pending.
  - Response: held pending.
  - Then rst mid-service -> depth_o=0, level_o=0, pending_o=0, all pulses 0.
